// File: rtl/multiphase_clock_divider_pkg.sv
// Shared types and helpers for the multiphase clock divider.
package multiphase_clkdiv_pkg;

    localparam int MAX_PHASES = 16;

    typedef enum logic {IDLE, RUN} clkdiv_state_t;

    function automatic int slice_width(input int phases);
        int w;
        w = $clog2(2 * phases);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/multiphase_clock_divider_if.sv
// Control/status bundle of the multiphase clock divider.
// cpol exists only when CLKDIV_POLARITY_EN is defined.
interface multiphase_clock_divider_if #(
    parameter int DIVIDER_WIDTH = 8,
    parameter int PHASES        = 2,
    parameter int BURST_WIDTH   = 16
);
    logic [DIVIDER_WIDTH-1:0] div_factor;
    logic [BURST_WIDTH-1:0]   burst_len;
    logic                     start;
    logic                     stop;
`ifdef CLKDIV_POLARITY_EN
    logic                     cpol;
`endif
    logic [PHASES-1:0]        phase_out;
    logic                     busy;
    logic                     period_tick;
    logic                     done;

    modport master (
        output div_factor, burst_len, start, stop,
`ifdef CLKDIV_POLARITY_EN
        output cpol,
`endif
        input  phase_out, busy, period_tick, done
    );

    modport slave (
        input  div_factor, burst_len, start, stop,
`ifdef CLKDIV_POLARITY_EN
        input  cpol,
`endif
        output phase_out, busy, period_tick, done
    );
endinterface

// File: rtl/multiphase_clock_divider_slice_counter.sv
// Sub-slice and slice counters; exposes next-state slice so phases can be registered.
module clkdiv_slice_counter
    import multiphase_clkdiv_pkg::*;
#(
    parameter int DIVIDER_WIDTH = 8,
    parameter int PHASES        = 2,
    localparam int SW           = slice_width(PHASES)
) (
    input  logic                     clk_in,
    input  logic                     reset_n,
    input  logic                     i_load,
    input  logic                     i_en,
    input  logic [DIVIDER_WIDTH-1:0] i_div,
    output logic [SW-1:0]            o_slice_nxt,
    output logic                     o_period_end
);
    localparam logic [SW-1:0] LAST_SLICE = SW'(2 * PHASES - 1);

    logic [DIVIDER_WIDTH-1:0] r_sub;
    logic [SW-1:0]            r_slice;
    logic [DIVIDER_WIDTH-1:0] w_sub_nxt;
    logic [SW-1:0]            w_slice_nxt;
    logic                     w_sub_wrap;

    assign w_sub_wrap   = (r_sub == i_div - DIVIDER_WIDTH'(1));
    assign o_period_end = i_en && w_sub_wrap && (r_slice == LAST_SLICE);
    assign o_slice_nxt  = w_slice_nxt;

    always_comb begin
        w_sub_nxt   = r_sub;
        w_slice_nxt = r_slice;
        if (i_load) begin
            w_sub_nxt   = '0;
            w_slice_nxt = '0;
        end else if (i_en) begin
            if (w_sub_wrap) begin
                w_sub_nxt   = '0;
                w_slice_nxt = (r_slice == LAST_SLICE) ? '0 : r_slice + SW'(1);
            end else begin
                w_sub_nxt = r_sub + DIVIDER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_sub   <= '0;
            r_slice <= '0;
        end else begin
            r_sub   <= w_sub_nxt;
            r_slice <= w_slice_nxt;
        end
    end
endmodule

// File: rtl/multiphase_clock_divider.sv
// Multiphase clock divider: FSM, burst counter, divider reload and phase decode.
// Define CLKDIV_POLARITY_EN to add the cpol idle-polarity input.
module multiphase_clock_divider
    import multiphase_clkdiv_pkg::*;
#(
    parameter int DIVIDER_WIDTH = 8,
    parameter int PHASES        = 2,
    parameter int BURST_WIDTH   = 16
) (
    input logic                        clk_in,
    input logic                        reset_n,
    multiphase_clock_divider_if.slave  bus
);
    // state | meaning
    // IDLE  | outputs at idle level, waiting for start
    // RUN   | generating periods until burst count or stop
    localparam int SW = slice_width(PHASES);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]               r_state;
    logic [DIVIDER_WIDTH-1:0] r_div;
    logic [BURST_WIDTH-1:0]   r_burst_len;
    logic [BURST_WIDTH-1:0]   r_period_cnt;
    logic                     r_stop_pending;
    logic [PHASES-1:0]        r_phase;
    logic                     r_busy;
    logic                     r_tick;
    logic                     r_done;

    logic [DIVIDER_WIDTH-1:0] w_div_eff;
    logic [BURST_WIDTH-1:0]   w_period_inc;
    logic [SW-1:0]            w_slice_nxt;
    logic [PHASES-1:0]        w_pattern;
    logic                     w_start;
    logic                     w_run;
    logic                     w_period_end;
    logic                     w_finish;
    logic                     w_idle_lvl;
    logic                     w_run_pol;

`ifdef CLKDIV_POLARITY_EN
    logic r_cpol;
    assign w_idle_lvl = bus.cpol;
    assign w_run_pol  = w_start ? bus.cpol : r_cpol;
    always_ff @(posedge clk_in) begin
        if (!reset_n)     r_cpol <= 1'b0;
        else if (w_start) r_cpol <= bus.cpol;
    end
`else
    assign w_idle_lvl = 1'b0;
    assign w_run_pol  = 1'b0;
`endif

    assign w_div_eff    = (bus.div_factor == '0) ? DIVIDER_WIDTH'(1) : bus.div_factor;
    assign w_start      = (r_state == ST_IDLE) && bus.start;
    assign w_run        = (r_state == ST_RUN);
    assign w_period_inc = r_period_cnt + BURST_WIDTH'(1);
    // A stop seen on the boundary cycle itself still ends the run at that boundary.
    assign w_finish     = w_period_end && (r_stop_pending || bus.stop ||
                          ((r_burst_len != '0) && (w_period_inc == r_burst_len)));

    clkdiv_slice_counter #(
        .DIVIDER_WIDTH (DIVIDER_WIDTH),
        .PHASES        (PHASES)
    ) u_slice_counter (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .i_load       (w_start),
        .i_en         (w_run),
        .i_div        (r_div),
        .o_slice_nxt  (w_slice_nxt),
        .o_period_end (w_period_end)
    );

    always_comb begin
        int si;
        int d;
        w_pattern = '0;
        si = int'(w_slice_nxt);
        for (int k = 0; k < PHASES; k++) begin
            d = (si >= k) ? (si - k) : (si + 2 * PHASES - k);
            w_pattern[k] = (d < PHASES);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_div          <= '0;
            r_burst_len    <= '0;
            r_period_cnt   <= '0;
            r_stop_pending <= 1'b0;
            r_phase        <= {PHASES{w_idle_lvl}};
            r_busy         <= 1'b0;
            r_tick         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state        <= ST_RUN;
                        r_div          <= w_div_eff;
                        r_burst_len    <= bus.burst_len;
                        r_period_cnt   <= '0;
                        r_stop_pending <= bus.stop;
                        r_busy         <= 1'b1;
                        r_tick         <= 1'b1;
                        r_phase        <= w_pattern ^ {PHASES{w_run_pol}};
                    end else begin
                        r_phase <= {PHASES{w_idle_lvl}};
                    end
                end
                ST_RUN: begin
                    if (bus.stop) r_stop_pending <= 1'b1;
                    if (w_period_end) r_period_cnt <= w_period_inc;
                    if (w_finish) begin
                        r_state        <= ST_IDLE;
                        r_stop_pending <= 1'b0;
                        r_busy         <= 1'b0;
                        r_done         <= 1'b1;
                        r_phase        <= {PHASES{w_idle_lvl}};
                    end else begin
                        if (w_period_end) begin
                            r_div  <= w_div_eff;
                            r_tick <= 1'b1;
                        end
                        r_phase <= w_pattern ^ {PHASES{w_run_pol}};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.phase_out   = r_phase;
    assign bus.busy        = r_busy;
    assign bus.period_tick = r_tick;
    assign bus.done        = r_done;
endmodule
